asmd_mult_arbiter: RTL and testbench

Shares one asmd_multiplier instance among num_req independent requesters. Requesters are served round-robin. The block latches the winning requester's operands and sequences the multiplier's start/ready handshake. It then returns the product to that requester with a one-cycle ack, and flags a sticky error if the multiplier never completes. It sits between client blocks and the multiplier's word0/word1/start/product/ready ports.

---
 rtl/asmd_mult_arbiter_if.sv | 32 +++
 rtl/asmd_mult_arbiter.sv | 162 ++++++++++++++++
 tb/tb_asmd_mult_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/asmd_mult_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals around the shared
// multiplier arbiter. The arbiter uses the slave view; clients and the
// multiplier (or a bench standing in for both) use the master view.
interface asmd_mult_arbiter_if #(
    parameter int word_length = 4,
    parameter int num_req     = 4,
    parameter int idx_width   = 2
);
    logic [num_req-1:0]             req;
    logic [num_req*word_length-1:0] req_word0;
    logic [num_req*word_length-1:0] req_word1;
    logic [num_req-1:0]             ack;
    logic [2*word_length-1:0]       result;
    logic [idx_width-1:0]           result_id;
    logic                           busy;
    logic                           err;
    logic [word_length-1:0]         mul_word0;
    logic [word_length-1:0]         mul_word1;
    logic                           mul_start;
    logic [2*word_length-1:0]       mul_product;
    logic                           mul_ready;

    modport slave (
        input  req, req_word0, req_word1, mul_product, mul_ready,
        output ack, result, result_id, busy, err, mul_word0, mul_word1, mul_start
    );

    modport master (
        output req, req_word0, req_word1, mul_product, mul_ready,
        input  ack, result, result_id, busy, err, mul_word0, mul_word1, mul_start
    );
endinterface

// File: rtl/asmd_mult_arbiter.sv
// Round-robin arbiter sharing one ASMD multiplier among several requesters.
// The winner's operands are latched, the multiplier start/ready handshake is
// sequenced, and the product is returned with a one-cycle one-hot ack. A
// multiplier that never finishes is aborted after timeout_cycles and raises
// a sticky error.
module asmd_mult_arbiter #(
    parameter int word_length    = 4,
    parameter int num_req        = 4,
    parameter int idx_width      = 2,
    parameter int timeout_cycles = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    asmd_mult_arbiter_if.slave      bus
);

    localparam int tmo_width = $clog2(timeout_cycles + 1);
    localparam logic [tmo_width-1:0] tmo_last = tmo_width'(timeout_cycles - 1);
    localparam logic [tmo_width-1:0] tmo_one  = tmo_width'(1'b1);
    localparam logic [idx_width-1:0] rr_init  = idx_width'(num_req - 1);
    localparam logic [num_req-1:0]   ack_one  = num_req'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4
    } state_t;

    state_t                   r_state;
    logic [idx_width-1:0]     r_rr_ptr;
    logic [idx_width-1:0]     r_gnt_id;
    logic [tmo_width-1:0]     r_tmo_cnt;
    logic [num_req-1:0]       r_ack;
    logic [2*word_length-1:0] r_result;
    logic [idx_width-1:0]     r_result_id;
    logic                     r_busy;
    logic                     r_err;
    logic [word_length-1:0]   r_mul_word0;
    logic [word_length-1:0]   r_mul_word1;
    logic                     r_mul_start;

    logic                     w_gnt_found;
    logic [idx_width-1:0]     w_gnt_idx;
    logic [idx_width-1:0]     w_cand;
    logic                     w_hit;
    logic [word_length-1:0]   w_op0;
    logic [word_length-1:0]   w_op1;

    // Round-robin search: walk from the farthest candidate to the nearest
    // (rr_ptr+1) so the nearest requesting index is the one left standing.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = {idx_width{1'b0}};
        w_cand      = {idx_width{1'b0}};
        w_hit       = 1'b0;
        for (int k = num_req; k >= 1; k--) begin
            w_cand      = idx_width'((int'(r_rr_ptr) + k) % num_req);
            w_hit       = bus.req[w_cand];
            w_gnt_found = w_gnt_found | w_hit;
            w_gnt_idx   = w_hit ? w_cand : w_gnt_idx;
        end
    end

    // Select the granted requester's operand pair from the packed buses.
    always_comb begin
        w_op0 = {word_length{1'b0}};
        w_op1 = {word_length{1'b0}};
        for (int i = 0; i < num_req; i++) begin
            w_op0 = (w_gnt_idx == idx_width'(i)) ? bus.req_word0[i*word_length +: word_length] : w_op0;
            w_op1 = (w_gnt_idx == idx_width'(i)) ? bus.req_word1[i*word_length +: word_length] : w_op1;
        end
    end

    // Control FSM with all outputs registered; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= rr_init;
            r_gnt_id    <= {idx_width{1'b0}};
            r_tmo_cnt   <= {tmo_width{1'b0}};
            r_ack       <= {num_req{1'b0}};
            r_result    <= {(2*word_length){1'b0}};
            r_result_id <= {idx_width{1'b0}};
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_mul_word0 <= {word_length{1'b0}};
            r_mul_word1 <= {word_length{1'b0}};
            r_mul_start <= 1'b0;
        end else begin
            r_ack <= {num_req{1'b0}};
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_found) begin
                        r_gnt_id    <= w_gnt_idx;
                        r_rr_ptr    <= w_gnt_idx;
                        r_mul_word0 <= w_op0;
                        r_mul_word1 <= w_op1;
                        r_mul_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_tmo_cnt   <= {tmo_width{1'b0}};
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_mul_start <= 1'b1;
                    r_state     <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // Hold start until the multiplier shows it has left ready.
                    if (!bus.mul_ready) begin
                        r_mul_start <= 1'b0;
                        r_state     <= ST_WAIT_DONE;
                    end else begin
                        r_mul_start <= 1'b1;
                        r_state     <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.mul_ready) begin
                        r_result    <= bus.mul_product;
                        r_result_id <= r_gnt_id;
                        r_ack       <= ack_one << r_gnt_id;
                        r_state     <= ST_RESPOND;
                    end else if (r_tmo_cnt == tmo_last) begin
                        // Multiplier never finished: answer with zero and flag it.
                        r_err       <= 1'b1;
                        r_result    <= {(2*word_length){1'b0}};
                        r_result_id <= r_gnt_id;
                        r_ack       <= ack_one << r_gnt_id;
                        r_state     <= ST_RESPOND;
                    end else begin
                        r_tmo_cnt   <= r_tmo_cnt + tmo_one;
                        r_state     <= ST_WAIT_DONE;
                    end
                end
                ST_RESPOND: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_mul_start <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack       = r_ack;
    assign bus.result    = r_result;
    assign bus.result_id = r_result_id;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
    assign bus.mul_word0 = r_mul_word0;
    assign bus.mul_word1 = r_mul_word1;
    assign bus.mul_start = r_mul_start;

endmodule

// File: tb/tb_asmd_mult_arbiter.sv
// Scoreboard bench for asmd_mult_arbiter: directed requests push expected
// (id, product) pairs into a queue; a forked monitor pops and compares on
// every ack. A small multiplier stub answers start with a fixed compute time
// and can be told to hang so the abort path is exercised.
module tb_asmd_mult_arbiter;

    logic clk;
    logic reset;

    asmd_mult_arbiter_if #(.word_length(4), .num_req(4), .idx_width(2)) bus ();

    asmd_mult_arbiter #(
        .word_length(4), .num_req(4), .idx_width(2), .timeout_cycles(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0] id;
        logic [7:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    // Multiplier stub
    logic       stub_ready;
    logic       stub_busy;
    logic       stub_hang;
    logic [2:0] stub_cnt;
    logic [7:0] stub_prod;
    logic [3:0] stub_a;
    logic [3:0] stub_b;

    assign bus.mul_ready   = stub_ready;
    assign bus.mul_product = stub_prod;

    always #5 clk = ~clk;

    // Stub: ready drops on start, product appears four edges later.
    always @(posedge clk) begin
        if (reset) begin
            stub_ready <= 1'b0;
            stub_busy  <= 1'b0;
            stub_cnt   <= 3'd0;
            stub_prod  <= 8'd0;
            stub_a     <= 4'd0;
            stub_b     <= 4'd0;
        end else if (stub_busy) begin
            if (stub_cnt == 3'd1) begin
                stub_ready <= 1'b1;
                stub_prod  <= {4'd0, stub_a} * {4'd0, stub_b};
                stub_busy  <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 3'd1;
            end
        end else if (bus.mul_start && !stub_hang) begin
            stub_a     <= bus.mul_word0;
            stub_b     <= bus.mul_word1;
            stub_busy  <= 1'b1;
            stub_ready <= 1'b0;
            stub_cnt   <= 3'd4;
        end else if (bus.mul_start) begin
            stub_ready <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    task automatic bound_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.ack != 4'd0) begin
                check("ack_onehot", {31'd0, $onehot(bus.ack)}, 32'd1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack actual=%0h required=none", bus.ack);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_vec",   {28'd0, bus.ack},       {28'd0, 4'b0001 << e.id});
                    check("result",    {24'd0, bus.result},    {24'd0, e.res});
                    check("result_id", {30'd0, bus.result_id}, {30'd0, e.id});
                end
            end
        end
    endtask

    task automatic wait_ack(output logic [3:0] seen);
        seen = 4'd0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.ack != 4'd0) begin
                seen = bus.ack;
                break;
            end
        end
        if (seen == 4'd0) bound_fail("wait_ack");
    endtask

    // Serve n acks; each requester drops on its ack and optionally re-arms.
    task automatic run_acks(input int n, input logic [3:0] rearm, input bit clear_end);
        logic [3:0] seen;
        for (int i = 0; i < n; i++) begin
            wait_ack(seen);
            bus.req = bus.req & ~seen;
            if (clear_end && i == n - 1) bus.req = 4'd0;
            if (i < n - 1) begin
                @(posedge clk);
                #1;
                bus.req = bus.req | (seen & rearm);
            end
        end
    endtask

    task automatic wait_wait_done();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.busy && !bus.mul_start && bus.ack == 4'd0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) bound_fail("wait_wait_done");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},       {28'd0, bus.ack},       32'd0);
        check({tag, "_result"},    {24'd0, bus.result},    32'd0);
        check({tag, "_result_id"}, {30'd0, bus.result_id}, 32'd0);
        check({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
        check({tag, "_err"},       {31'd0, bus.err},       32'd0);
        check({tag, "_mul_word0"}, {28'd0, bus.mul_word0}, 32'd0);
        check({tag, "_mul_word1"}, {28'd0, bus.mul_word1}, 32'd0);
        check({tag, "_mul_start"}, {31'd0, bus.mul_start}, 32'd0);
    endtask

    initial begin
        int starts;
        int wd_cycles;
        bit got;
        clk           = 1'b0;
        reset         = 1'b1;
        stub_hang     = 1'b0;
        total         = 0;
        bad           = 0;
        bus.req       = 4'd0;
        bus.req_word0 = 16'd0;
        bus.req_word1 = 16'd0;
        fork
            monitor_loop();
        join_none
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        reset = 1'b0;
        @(negedge clk);

        // Single request 4*5
        bus.req_word0[3:0] = 4'd4;
        bus.req_word1[3:0] = 4'd5;
        push(2'd0, 8'h14);
        bus.req = 4'b0001;
        starts  = 0;
        got     = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.mul_start) starts++;
            if (bus.ack != 4'd0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) bound_fail("single_ack");
        bus.req = 4'd0;
        check("start_cycles", starts, 32'd2);
        @(negedge clk);
        check("busy_after_respond", {31'd0, bus.busy}, 32'd0);
        check("ack_one_cycle", {28'd0, bus.ack}, 32'd0);

        // Contention: req0 3*7 and req1 15*15 together
        do_reset();
        bus.req_word0[7:0] = {4'd15, 4'd3};
        bus.req_word1[7:0] = {4'd15, 4'd7};
        push(2'd0, 8'h15);
        push(2'd1, 8'hE1);
        bus.req = 4'b0011;
        run_acks(2, 4'd0, 1'b1);

        // Round-robin: operands i*2 and 3, all requesting
        do_reset();
        bus.req_word0 = {4'd6, 4'd4, 4'd2, 4'd0};
        bus.req_word1 = {4'd3, 4'd3, 4'd3, 4'd3};
        push(2'd0, 8'd0);
        push(2'd1, 8'd6);
        push(2'd2, 8'd12);
        push(2'd3, 8'd18);
        push(2'd0, 8'd0);
        push(2'd1, 8'd6);
        bus.req = 4'b1111;
        run_acks(6, 4'b1111, 1'b1);

        // Boundaries with operand churn during WAIT_DONE
        @(negedge clk);
        bus.req_word0 = {4'd15, 4'd0, 4'd0, 4'd0};
        bus.req_word1 = {4'd15, 4'd9, 4'd0, 4'd0};
        push(2'd2, 8'h00);
        bus.req = 4'b0100;
        wait_wait_done();
        for (int i = 0; i < 3; i++) begin
            check("hold0_w0", {28'd0, bus.mul_word0}, 32'd0);
            check("hold0_w1", {28'd0, bus.mul_word1}, 32'd9);
            bus.req_word0 = ~bus.req_word0;
            bus.req_word1 = ~bus.req_word1;
            @(negedge clk);
        end
        run_acks(1, 4'd0, 1'b1);
        bus.req_word0 = {4'd15, 4'd0, 4'd0, 4'd0};
        bus.req_word1 = {4'd15, 4'd9, 4'd0, 4'd0};
        push(2'd3, 8'hE1);
        bus.req = 4'b1000;
        wait_wait_done();
        for (int i = 0; i < 3; i++) begin
            check("hold15_w0", {28'd0, bus.mul_word0}, 32'd15);
            check("hold15_w1", {28'd0, bus.mul_word1}, 32'd15);
            bus.req_word0 = ~bus.req_word0;
            bus.req_word1 = ~bus.req_word1;
            @(negedge clk);
        end
        run_acks(1, 4'd0, 1'b1);

        // Reset during WAIT_DONE drops the op
        @(negedge clk);
        bus.req_word0 = {4'd0, 4'd0, 4'd5, 4'd2};
        bus.req_word1 = {4'd0, 4'd0, 4'd5, 4'd6};
        bus.req = 4'b0010;
        wait_wait_done();
        reset   = 1'b1;
        bus.req = 4'd0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        repeat (10) @(negedge clk);
        push(2'd0, 8'h0C);
        bus.req = 4'b0001;
        run_acks(1, 4'd0, 1'b1);

        // Timeout with a hung multiplier
        @(negedge clk);
        stub_hang     = 1'b1;
        bus.req_word0 = {4'd0, 4'd4, 4'd3, 4'd0};
        bus.req_word1 = {4'd0, 4'd4, 4'd3, 4'd0};
        push(2'd1, 8'h00);
        bus.req   = 4'b0010;
        wd_cycles = 0;
        got       = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.ack != 4'd0) begin
                got = 1'b1;
                break;
            end
            if (bus.busy && !bus.mul_start) wd_cycles++;
        end
        if (!got) bound_fail("timeout_ack");
        bus.req = 4'd0;
        check("timeout_wd_cycles", wd_cycles, 32'd8);
        check("timeout_err", {31'd0, bus.err}, 32'd1);
        stub_hang = 1'b0;
        repeat (5) @(negedge clk);
        check("err_sticky_idle", {31'd0, bus.err}, 32'd1);
        push(2'd2, 8'h10);
        bus.req = 4'b0100;
        run_acks(1, 4'd0, 1'b1);
        check("err_sticky_op", {31'd0, bus.err}, 32'd1);
        do_reset();
        check("err_cleared", {31'd0, bus.err}, 32'd0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
